// File: rtl/p_hardisc.sv
// Shared types for the carry-less multiplier: Zbc function codes, FSM states
// and the result-window selection helper.
package p_hardisc;

  typedef enum logic [1:0] {
    CLMUL_L = 2'd0,
    CLMUL_H = 2'd1,
    CLMUL_R = 2'd2
  } clmul_fn;

  typedef enum logic [1:0] {
    CLS_IDLE = 2'd0,
    CLS_BUSY = 2'd1,
    CLS_DONE = 2'd2
  } clmul_state;

  localparam int unsigned CLMUL_XLEN = 32;

  // Picks the 32-bit window of the 64-bit product that each Zbc op returns;
  // the reserved code yields zero.
  function automatic logic [CLMUL_XLEN-1:0] clmul_select(input logic [1:0]              fn,
                                                         input logic [2*CLMUL_XLEN-1:0] p);
    logic [CLMUL_XLEN-1:0] r;
    r = '0;
    case (fn)
      CLMUL_L: r = p[31:0];
      CLMUL_H: r = p[63:32];
      CLMUL_R: r = p[62:31];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clmul_step.sv
// One iteration of the carry-less multiply: XOR of the BPC partial products
// selected by the low multiplier bits of this step.
module clmul_step #(
  parameter int unsigned BPC = 4
) (
  input  logic [63:0]    a_i,
  input  logic [BPC-1:0] b_i,
  output logic [63:0]    pp_o
);

  // NOTE: blocking '=' is correct here: each loop pass must see the running
  // XOR from the previous pass within the same evaluation.
  always_comb begin
    pp_o = '0;
    for (int k = 0; k < BPC; k++) begin
      if (b_i[k]) pp_o = pp_o ^ (a_i << k);
    end
  end

endmodule

// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) with valid/ready on
// both sides. Optional CLMUL_EARLY_EXIT_EN finishes once the multiplier is exhausted.
module clmul_unit
  import p_hardisc::*;
#(
  parameter int unsigned BPC = 4
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [1:0]  s_function_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_result_o
);

  localparam int unsigned STEPS = 32 / BPC;
  localparam int unsigned CNT_W = $clog2(STEPS) + 1;

  if (BPC == 0 || BPC > 32 || (32 % BPC) != 0) begin : g_bpc_check
    $error("clmul_unit: BPC must divide 32");
  end

  clmul_state        state_q, state_d;
  logic [1:0]        fn_q, fn_d;
  logic [63:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [63:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;

  logic [63:0]       pp;
  logic [63:0]       step_acc;
  logic [31:0]       step_b;
  logic              last_step;
  logic              start_done;

  clmul_step #(.BPC(BPC)) u_step (
    .a_i  (a_q),
    .b_i  (b_q[BPC-1:0]),
    .pp_o (pp)
  );

  assign step_acc = acc_q ^ pp;
  assign step_b   = b_q >> BPC;

`ifdef CLMUL_EARLY_EXIT_EN
  assign last_step  = (cnt_q == CNT_W'(STEPS - 1)) || (step_b == '0);
  assign start_done = (s_op2_i == '0);
`else
  assign last_step  = (cnt_q == CNT_W'(STEPS - 1));
  assign start_done = 1'b0;
`endif

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    // Flush dominates both a fresh accept and the result handshake.
    if (s_flush_i) begin
      state_d = CLS_IDLE;
    end else begin
      case (state_q)
        CLS_IDLE: begin
          if (s_valid_i) begin
            fn_d  = s_function_i;
            a_d   = {32'b0, s_op1_i};
            b_d   = s_op2_i;
            acc_d = '0;
            cnt_d = '0;
            if (start_done) begin
              state_d  = CLS_DONE;
              result_d = '0;
            end else begin
              state_d  = CLS_BUSY;
            end
          end
        end
        CLS_BUSY: begin
          acc_d = step_acc;
          a_d   = a_q << BPC;
          b_d   = step_b;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d  = CLS_DONE;
            result_d = clmul_select(fn_q, step_acc);
          end
        end
        CLS_DONE: begin
          if (s_ready_i) state_d = CLS_IDLE;
        end
        default: state_d = CLS_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q  <= CLS_IDLE;
      fn_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign s_ready_o  = (state_q == CLS_IDLE);
  assign s_valid_o  = (state_q == CLS_DONE);
  assign s_result_o = result_q;

endmodule

// File: tb/tb_clmul_unit.sv
// Scoreboard bench for clmul_unit: driver pushes reference results, a monitor
// pops on each result handshake and checks value, latency and hold stability.
module tb_clmul_unit;

  localparam int unsigned BPC = 4;

  typedef struct {
    logic [31:0] res;
    int          req_cyc;
    int          lat;
  } exp_t;

  logic        s_clk_i = 1'b0;
  logic        s_resetn_i = 1'b0;
  logic        s_flush_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [1:0]  s_function_i = '0;
  logic [31:0] s_op1_i = '0;
  logic [31:0] s_op2_i = '0;
  logic        s_valid_o;
  logic        s_ready_i = 1'b0;
  logic [31:0] s_result_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   force_hold = 1'b0;
  exp_t exp_q[$];

  clmul_unit #(.BPC(BPC)) dut (
    .s_clk_i      (s_clk_i),
    .s_resetn_i   (s_resetn_i),
    .s_flush_i    (s_flush_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_function_i (s_function_i),
    .s_op1_i      (s_op1_i),
    .s_op2_i      (s_op2_i),
    .s_valid_o    (s_valid_o),
    .s_ready_i    (s_ready_i),
    .s_result_o   (s_result_o)
  );

  always #5 s_clk_i = ~s_clk_i;
  always @(posedge s_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: full 64-bit carry-less product from its definition.
  function automatic logic [31:0] ref_clmul(input logic [1:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
    case (fn)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  // Cycles from the request cycle to the first cycle showing a result.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef CLMUL_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return msb / BPC + 2;
`else
    return 32 / BPC + 1;
`endif
  endfunction

  task automatic issue(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it);
    int guard;
    guard = 0;
    @(negedge s_clk_i);
    while (!s_ready_o) begin
      guard++;
      if (guard > 200) begin
        fail_now("ready_timeout");
        return;
      end
      @(negedge s_clk_i);
    end
    s_valid_i    = 1'b1;
    s_function_i = fn;
    s_op1_i      = a;
    s_op2_i      = b;
    if (expect_it) exp_q.push_back('{res: ref_clmul(fn, a, b), req_cyc: cyc, lat: exp_lat(b)});
    @(negedge s_clk_i);
    s_valid_i    = 1'b0;
    s_function_i = 2'($urandom);
    s_op1_i      = $urandom;
    s_op2_i      = $urandom;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 || !s_ready_o) begin
      guard++;
      if (guard > 300) begin
        fail_now("drain_timeout");
        return;
      end
      @(negedge s_clk_i);
    end
  endtask

  // Monitor: consumer side, randomised back-pressure plus hold checks.
  initial begin : monitor
    exp_t        e;
    bit          prev_valid;
    logic [31:0] prev_res;
    int          hold;
    int          waited;
    prev_valid = 1'b0;
    prev_res   = '0;
    hold       = 0;
    waited     = 0;
    forever begin
      @(negedge s_clk_i);
      if (!s_resetn_i) begin
        prev_valid = 1'b0;
        s_ready_i  = 1'b0;
      end else begin
        if (prev_valid) begin
          check("valid_held", 64'(s_valid_o), 64'd1);
          check("result_held", 64'(s_result_o), 64'(prev_res));
        end
        if (s_valid_o) begin
          check("ready_low_in_done", 64'(s_ready_o), 64'd0);
          if (!prev_valid) begin
            waited = 0;
            hold   = force_hold ? 5 : int'($urandom_range(0, 2));
            if (exp_q.size() == 0) fail_now("unexpected_result");
            else check("latency", 64'(cyc - exp_q[0].req_cyc), 64'(exp_q[0].lat));
          end
          if (waited >= hold) begin
            s_ready_i  = 1'b1;
            prev_valid = 1'b0;
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("result", 64'(s_result_o), 64'(e.res));
            end
          end else begin
            s_ready_i  = 1'b0;
            waited++;
            prev_valid = 1'b1;
            prev_res   = s_result_o;
          end
        end else begin
          prev_valid = 1'b0;
          s_ready_i  = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] r1, r2;
    #1;
    check("rst_ready", 64'(s_ready_o), 64'd1);
    check("rst_valid", 64'(s_valid_o), 64'd0);
    check("rst_result", 64'(s_result_o), 64'd0);
    repeat (2) @(negedge s_clk_i);
    s_resetn_i = 1'b1;

    issue(2'd0, 32'd3, 32'd3, 1'b1);
    wait_idle();
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(2'd2, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    issue(2'd0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue(2'd1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
    wait_idle();

    // Consumer stalls five cycles in DONE.
    force_hold = 1'b1;
    issue(2'd0, 32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b1);
    wait_idle();
    force_hold = 1'b0;

    // Flush mid-BUSY: nothing may be presented afterwards.
    issue(2'd0, 32'd3, 32'h8000_0003, 1'b0);
    repeat (2) @(negedge s_clk_i);
    s_flush_i = 1'b1;
    @(negedge s_clk_i);
    s_flush_i = 1'b0;
    check("flush_ready", 64'(s_ready_o), 64'd1);
    check("flush_valid", 64'(s_valid_o), 64'd0);
    repeat (12) @(negedge s_clk_i);
    issue(2'd0, 32'd3, 32'd3, 1'b1);
    wait_idle();

    // Flush and request in the same IDLE cycle: request must be dropped.
    s_valid_i = 1'b1;
    s_flush_i = 1'b1;
    s_op2_i   = 32'h8000_0000;
    @(negedge s_clk_i);
    s_valid_i = 1'b0;
    s_flush_i = 1'b0;
    check("flush_beats_accept", 64'(s_ready_o), 64'd1);
    repeat (12) @(negedge s_clk_i);

    // Asynchronous reset mid-operation.
    issue(2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    repeat (2) @(negedge s_clk_i);
    #2 s_resetn_i = 1'b0;
    #1;
    check("arst_ready", 64'(s_ready_o), 64'd1);
    check("arst_valid", 64'(s_valid_o), 64'd0);
    check("arst_result", 64'(s_result_o), 64'd0);
    @(posedge s_clk_i);
    #2 s_resetn_i = 1'b1;
    issue(2'd0, 32'd3, 32'd3, 1'b1);
    wait_idle();

    for (int n = 0; n < 150; n++) begin
      r1 = $urandom;
      r2 = $urandom;
      if (n % 3 == 0) r2 = r2 >> $urandom_range(0, 31);
      if (n % 17 == 0) r2 = '0;
      issue(2'($urandom_range(0, 3)), r1, r2, 1'b1);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
